// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS Execute-stage multiply/divide unit with HI/LO and busy latency model
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         w_op_nxt;
    logic [31:0]        w_a_nxt;
    logic [31:0]        w_b_nxt;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;

    logic               w_is_md;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_den_s;
    logic [31:0]        w_den_u;
    logic [31:0]        w_sq_mag;
    logic [31:0]        w_sr_mag;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic               w_div_zero;

    assign w_is_md  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign busy     = (r_state == S_RUN);
    assign md_stall = busy | (start & w_is_md);
    assign hi       = r_hi;
    assign lo       = r_lo;

    // Arithmetic from latched operands; signed multiply via sign-extended 64-bit product
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide done on magnitudes so the most-negative/-1 case wraps to 0x80000000 cleanly;
    // the zero divisor is replaced by 1 only to keep the divider well defined, the result is discarded
    assign w_div_zero = (r_b == 32'd0);
    assign w_abs_a    = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_abs_b    = r_b[31] ? (32'd0 - r_b) : r_b;
    assign w_den_s    = w_div_zero ? 32'd1 : w_abs_b;
    assign w_den_u    = w_div_zero ? 32'd1 : r_b;
    assign w_sq_mag   = w_abs_a / w_den_s;
    assign w_sr_mag   = w_abs_a % w_den_s;
    assign w_sq       = (r_a[31] ^ r_b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr       = r_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq       = r_a / w_den_u;
    assign w_ur       = r_a % w_den_u;

    // State register and datapath registers; reset aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next-state: accept ops or mthi/mtlo in IDLE, count down and commit in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_is_md) begin
                        w_op_nxt    = md_op;
                        w_a_nxt     = rs_val;
                        w_b_nxt     = rt_val;
                        w_cnt_nxt   = (md_op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        w_state_nxt = S_RUN;
                    end else if (md_op == OP_MTHI) begin
                        w_hi_nxt = rs_val;
                    end else if (md_op == OP_MTLO) begin
                        w_lo_nxt = rs_val;
                    end
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    case (r_op)
                        OP_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
                        OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
                        OP_DIV: begin
                            if (!w_div_zero) begin
                                w_lo_nxt = w_sq;
                                w_hi_nxt = w_sr;
                            end
                        end
                        OP_DIVU: begin
                            if (!w_div_zero) begin
                                w_lo_nxt = w_uq;
                                w_hi_nxt = w_ur;
                            end
                        end
                        default: begin
                            w_hi_nxt = r_hi;
                        end
                    endcase
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_errors;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an MD op at a negedge, then count busy cycles sampled at negedges
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output int stall_lo, output logic stall_acc);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1;
        stall_acc = md_stall;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        n = 0;
        stall_lo = 0;
        while (busy && n < 50) begin
            n++;
            if (!md_stall) stall_lo++;
            @(negedge clk);
        end
    endtask

    // mthi/mtlo/no-op for one cycle starting at a negedge
    task automatic mt(input logic [2:0] op, input logic [31:0] v, input string tag);
        start  = 1'b1;
        md_op  = op;
        rs_val = v;
        #1;
        check(tag, {31'd0, md_stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
    endtask

    int   n;
    int   slo;
    logic sacc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        md_op  = 3'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", {31'd0, md_stall}, 32'd0);
        reset = 1'b1;

        // mult 3 * -4 = -12
        run_op(3'd1, 32'd3, 32'hFFFFFFFC, n, slo, sacc);
        check("mult_stall_acc", {31'd0, sacc}, 32'd1);
        check("mult_busy_n", n, 32'd5);
        check("mult_stall_busy", slo, 32'd0);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF4);

        // multu all-ones squared
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, n, slo, sacc);
        check("multu_busy_n", n, 32'd5);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        // div -7 / 2
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, n, slo, sacc);
        check("div_busy_n", n, 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        // div overflow case
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, n, slo, sacc);
        check("divov_lo", lo, 32'h80000000);
        check("divov_hi", hi, 32'h00000000);

        // divu 100 / 7
        run_op(3'd4, 32'd100, 32'd7, n, slo, sacc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // preload then divide by zero
        mt(3'd5, 32'h11, "mthi_stall");
        mt(3'd6, 32'h22, "mtlo_stall");
        check("mthi_hi", hi, 32'h11);
        check("mtlo_lo", lo, 32'h22);
        mt(3'd7, 32'h99, "nop7_stall");
        check("nop7_hi", hi, 32'h11);
        check("nop7_lo", lo, 32'h22);
        run_op(3'd4, 32'd7, 32'd0, n, slo, sacc);
        check("div0_busy_n", n, 32'd10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        // div -20 / 3 with an mtlo pulse at busy cycle 3, which must be ignored
        start  = 1'b1;
        md_op  = 3'd3;
        rs_val = 32'hFFFFFFEC;
        rt_val = 32'd3;
        @(negedge clk);
        n = 0;
        while (busy && n < 50) begin
            n++;
            if (n == 4) check("ign_mtlo_lo", lo, 32'h22);
            if (n == 3) begin
                start  = 1'b1;
                md_op  = 3'd6;
                rs_val = 32'hABCD;
                rt_val = 32'd1;
            end else begin
                start = 1'b0;
                md_op = 3'd0;
            end
            @(negedge clk);
        end
        check("ign_busy_n", n, 32'd10);
        check("ign_lo", lo, 32'hFFFFFFFA);
        check("ign_hi", hi, 32'hFFFFFFFE);

        // reset at busy cycle 6 aborts the divide
        start  = 1'b1;
        md_op  = 3'd3;
        rs_val = 32'd50;
        rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        repeat (5) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        check("abort_stay_idle", {31'd0, busy}, 32'd0);

        // mult 6 * -7, then mtlo in the cycle busy falls
        run_op(3'd1, 32'd6, 32'hFFFFFFF9, n, slo, sacc);
        check("b2b_busy_n", n, 32'd5);
        check("b2b_prod_lo", lo, 32'hFFFFFFD6);
        mt(3'd6, 32'd5, "b2b_mtlo_stall");
        check("b2b_lo", lo, 32'd5);
        check("b2b_hi", hi, 32'hFFFFFFFF);
        check("b2b_busy", {31'd0, busy}, 32'd0);

        // new mult accepted the cycle busy falls, sees committed result via hi/lo
        run_op(3'd2, 32'd10, 32'd20, n, slo, sacc);
        run_op(3'd2, 32'd3, 32'd4, n, slo, sacc);
        check("b2b2_busy_n", n, 32'd5);
        check("b2b2_lo", lo, 32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
